// File: rtl/c2h_packet_packer_if.sv
// Bus bundle for c2h_packet_packer: the narrow input stream from user logic
// and the package handshake consumed by the C2H AXI-Stream writer.
// The master side drives beats and data_next; the packer is the slave.
interface c2h_packet_packer_if #(
    parameter int IN_W  = 64,
    parameter int PKT_W = 4072
);
    logic [IN_W-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [PKT_W-1:0] data;
    logic             data_valid;
    logic             data_next;

    modport master (
        output s_tdata, s_tvalid, s_tlast, data_next,
        input  s_tready, data, data_valid
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, data_next,
        output s_tready, data, data_valid
    );
endinterface

// File: rtl/c2h_packet_packer.sv
// c2h_packet_packer: gathers IN_W-bit stream beats into PKT_W-bit packages
// for the C2H writer. Two package buffers ping-pong so one fills while the
// other is presented; input stalls only when both are full.
// Optional build macro C2H_PACK_SEQNUM_EN stamps a 32-bit package sequence
// number into bits [31:0] of every package as it closes.
module c2h_packet_packer #(
    parameter int IN_W  = 64,
    parameter int PKT_W = 4072
) (
    input  logic                  m_axis_c2h_aclk,
    input  logic                  m_axis_c2h_aresetn,
    input  logic                  en,
    c2h_packet_packer_if.slave    bus,
    output logic [15:0]           pkt_count,
    output logic [6:0]            fill_beats
);
    localparam int         BEATS     = (PKT_W + IN_W - 1) / IN_W;
    localparam logic [6:0] LAST_BEAT = 7'(BEATS - 1);

    typedef enum logic {FILL, STALL} fill_state_e;

    fill_state_e      state_q, state_d;
    logic [PKT_W-1:0] buf_q [2];
    logic [PKT_W-1:0] buf_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [6:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]      pkt_count_q, pkt_count_d;
    logic [PKT_W-1:0] data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             tready_en_q;
    logic             tready;
    logic             accept;
    logic             closing;
    logic             consume;
    logic [PKT_W-1:0] slot;
`ifdef C2H_PACK_SEQNUM_EN
    logic [31:0]      seq_q, seq_d;
`endif

    assign bus.s_tready   = tready;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign pkt_count      = pkt_count_q;
    assign fill_beats     = beat_cnt_q;

    // Next-state for the fill FSM, both buffers and the presented output.
    always_comb begin
        state_d     = state_q;
        buf_d[0]    = buf_q[0];
        buf_d[1]    = buf_q[1];
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
`ifdef C2H_PACK_SEQNUM_EN
        seq_d       = seq_q;
`endif
        // Beats wider than the tail of the package simply fall off the top.
        slot    = PKT_W'(bus.s_tdata) << (int'(beat_cnt_q) * IN_W);
        tready  = tready_en_q && !en && (state_q == FILL) && !full_q[wr_sel_q];
        accept  = bus.s_tvalid && tready;
        closing = accept && ((beat_cnt_q == LAST_BEAT) || bus.s_tlast);
        consume = data_valid_q && bus.data_next;

        // A consumed buffer is zeroed so the next fill can OR beats in.
        if (consume) begin
            buf_d[rd_sel_q]  = '0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            pkt_count_d      = pkt_count_q + 16'd1;
        end

        // consume and accept never target the same buffer: one needs it full,
        // the other needs it empty.
        if (accept) begin
            buf_d[wr_sel_q] = buf_q[wr_sel_q] | slot;
            beat_cnt_d      = beat_cnt_q + 7'd1;
        end

        if (closing) begin
`ifdef C2H_PACK_SEQNUM_EN
            buf_d[wr_sel_q][31:0] = seq_q;
            seq_d                 = seq_q + 32'd1;
`endif
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            beat_cnt_d       = '0;
        end

        case (state_q)
            FILL:    if (closing && full_d[!wr_sel_q]) state_d = STALL;
            STALL:   if (!full_d[wr_sel_q])            state_d = FILL;
            default: state_d = FILL;
        endcase

        // Registered view of whichever buffer will be presented next cycle.
        data_d       = rd_sel_d ? buf_d[1] : buf_d[0];
        data_valid_d = full_d[rd_sel_d];
    end

    // State register; reset and en both discard every partial or full package.
    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            state_q      <= FILL;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            beat_cnt_q   <= '0;
            pkt_count_q  <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            tready_en_q  <= 1'b0;
`ifdef C2H_PACK_SEQNUM_EN
            seq_q        <= '0;
`endif
        end else if (en) begin
            state_q      <= FILL;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            beat_cnt_q   <= '0;
            pkt_count_q  <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            tready_en_q  <= 1'b0;
`ifdef C2H_PACK_SEQNUM_EN
            seq_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q[0]     <= buf_d[0];
            buf_q[1]     <= buf_d[1];
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_count_q  <= pkt_count_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            tready_en_q  <= 1'b1;
`ifdef C2H_PACK_SEQNUM_EN
            seq_q        <= seq_d;
`endif
        end
    end
endmodule

// File: tb/tb_c2h_packet_packer.sv
// Directed bench for c2h_packet_packer: full packages, double-buffer stall,
// early close, continuous flow, and mid-package reset / en clear.
module tb_c2h_packet_packer;
    localparam int IN_W  = 64;
    localparam int PKT_W = 4072;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] pkt_count;
    logic [6:0]  fill_beats;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mvals [64];
    int          w;
    int          stalls;

    c2h_packet_packer_if #(.IN_W(IN_W), .PKT_W(PKT_W)) bus ();

    c2h_packet_packer #(.IN_W(IN_W), .PKT_W(PKT_W)) dut (
        .m_axis_c2h_aclk    (clk),
        .m_axis_c2h_aresetn (aresetn),
        .en                 (en),
        .bus                (bus),
        .pkt_count          (pkt_count),
        .fill_beats         (fill_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic [PKT_W-1:0] exp);
        logic [4095:0] a;
        logic [4095:0] b;
        int bad = 0;
        int first = 0;
        a = '0;
        b = '0;
        a[PKT_W-1:0] = bus.data;
        b[PKT_W-1:0] = exp;
        for (int i = 0; i < 64; i++) begin
            if (a[i*64 +: 64] !== b[i*64 +: 64]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s bad_words=%0d first_word=%0d observed=%0h expected=%0h",
                   tag, bad, first, a[first*64 +: 64], b[first*64 +: 64]);
        end
    endtask

    // Expected package from mvals[0..n-1]; slot i at bits i*64, clipped to PKT_W.
    function automatic logic [PKT_W-1:0] model(input int n, input int seq);
        logic [4095:0]    t;
        logic [PKT_W-1:0] r;
        t = '0;
        for (int i = 0; i < n; i++) t[i*64 +: 64] = mvals[i];
        r = t[PKT_W-1:0];
`ifdef C2H_PACK_SEQNUM_EN
        r[31:0] = 32'(seq);
`endif
        return r;
    endfunction

    // Expected low word of a package whose first beat is g.
    function automatic logic [63:0] w0(input logic [63:0] g, input int seq);
        logic [63:0] r;
        r = g;
`ifdef C2H_PACK_SEQNUM_EN
        r[31:0] = 32'(seq);
`endif
        return r;
    endfunction

    // Called and returns at a negedge; the beat is taken at the posedge between.
    task automatic beat(input logic [63:0] d, input logic last, output int waited);
        bus.s_tdata  = d;
        bus.s_tvalid = 1'b1;
        bus.s_tlast  = last;
        waited = 0;
        while (bus.s_tready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        assert (waited < 200) else begin
            errors++;
            $error("FAIL beat_timeout observed=%0d expected=<200", waited);
        end
        if (waited < 200) @(negedge clk);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic send(input logic [63:0] base, input int n, input logic last, output int st);
        int wt;
        st = 0;
        for (int i = 0; i < n; i++) begin
            mvals[i] = base + 64'(i);
            beat(base + 64'(i), last && (i == n - 1), wt);
            st += wt;
        end
    endtask

    task automatic pulse_next();
        bus.data_next = 1'b1;
        @(negedge clk);
        bus.data_next = 1'b0;
    endtask

    initial begin
        bus.s_tdata   = '0;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        bus.data_next = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tready", 64'(bus.s_tready), 64'd0);
        chk("rst_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_fill", 64'(fill_beats), 64'd0);
        chk_pkt("rst_data", '0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 64'(bus.s_tready), 64'd1);

        // Full package: 64 beats of beat index
        send(64'd0, 63, 1'b0, stalls);
        chk("t1_valid_before_close", 64'(bus.data_valid), 64'd0);
        chk("t1_fill_63", 64'(fill_beats), 64'd63);
        mvals[63] = 64'd63;
        beat(64'd63, 1'b0, w);
        chk("t1_valid", 64'(bus.data_valid), 64'd1);
        chk("t1_word0", bus.data[63:0], w0(64'd0, 0));
        chk("t1_word1", bus.data[127:64], 64'd1);
        chk("t1_top40", 64'(bus.data[4071:4032]), 64'd63);
        chk("t1_fill_end", 64'(fill_beats), 64'd0);
        chk_pkt("t1_pkt", model(64, 0));
        chk("t1_tready", 64'(bus.s_tready), 64'd1);

        // Second package fills the other buffer; both full stalls input
        send(64'd64, 64, 1'b0, stalls);
        chk("t2_tready_stall", 64'(bus.s_tready), 64'd0);
        chk("t2_still_pkt1", bus.data[63:0], w0(64'd0, 0));
        pulse_next();
        chk("t2_pkt_count", 64'(pkt_count), 64'd1);
        chk("t2_word0", bus.data[63:0], w0(64'd64, 1));
        chk("t2_tready_resume", 64'(bus.s_tready), 64'd1);
        chk_pkt("t2_pkt", model(64, 1));
        pulse_next();
        chk("t2_drained_valid", 64'(bus.data_valid), 64'd0);
        chk("t2_drained_count", 64'(pkt_count), 64'd2);
        chk_pkt("t2_drained_data", '0);

        // Early close after 3 beats
        send(64'hA, 3, 1'b1, stalls);
        chk("t3_valid", 64'(bus.data_valid), 64'd1);
        chk("t3_fill", 64'(fill_beats), 64'd0);
        chk("t3_word2", bus.data[191:128], 64'hC);
        chk_pkt("t3_pkt", model(3, 2));
        pulse_next();
        chk("t3_pkt_count", 64'(pkt_count), 64'd3);

        // s_tlast on the very first beat gives a one-beat package
        send(64'h55, 1, 1'b1, stalls);
        chk("t3b_valid", 64'(bus.data_valid), 64'd1);
        chk_pkt("t3b_pkt", model(1, 3));
        pulse_next();
        chk("t3b_pkt_count", 64'(pkt_count), 64'd4);

        // data_next with nothing presented is ignored
        pulse_next();
        chk("t3c_ignored_next", 64'(pkt_count), 64'd4);

        // Continuous flow from a clean reset: 640 beats, consumer always ready
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("t4_rst_count", 64'(pkt_count), 64'd0);
        bus.data_next = 1'b1;
        begin
            int flow_stalls = 0;
            int next_pk = 0;
            int bad_seq = 0;
            fork
                begin
                    int wt;
                    for (int g = 0; g < 640; g++) begin
                        beat(64'(g), 1'b0, wt);
                        flow_stalls += wt;
                    end
                end
                begin
                    for (int c = 0; c < 660; c++) begin
                        @(negedge clk);
                        if (bus.data_valid === 1'b1) begin
                            if (bus.data[63:0] !== w0(64'(next_pk * 64), next_pk)) bad_seq++;
                            next_pk++;
                        end
                    end
                end
            join
            bus.data_next = 1'b0;
            chk("t4_tready_never_low", 64'(flow_stalls), 64'd0);
            chk("t4_packages_seen", 64'(next_pk), 64'd10);
            chk("t4_order", 64'(bad_seq), 64'd0);
        end
        chk("t4_pkt_count", 64'(pkt_count), 64'd10);
        chk("t4_valid_end", 64'(bus.data_valid), 64'd0);

        // Mid-package async reset discards the partial package
        send(64'd100, 30, 1'b0, stalls);
        chk("t5_fill_30", 64'(fill_beats), 64'd30);
        aresetn = 1'b0;
        #1;
        chk("t5_rst_fill", 64'(fill_beats), 64'd0);
        chk("t5_rst_tready", 64'(bus.s_tready), 64'd0);
        chk("t5_rst_count", 64'(pkt_count), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        send(64'd200, 64, 1'b0, stalls);
        chk("t5_valid", 64'(bus.data_valid), 64'd1);
        chk("t5_word0", bus.data[63:0], w0(64'd200, 0));
        chk_pkt("t5_pkt", model(64, 0));
        pulse_next();
        chk("t5_only_one", 64'(bus.data_valid), 64'd0);
        chk("t5_pkt_count", 64'(pkt_count), 64'd1);

        // Same with a one-cycle en clear
        send(64'd300, 30, 1'b0, stalls);
        en = 1'b1;
        #1;
        chk("t6_en_tready", 64'(bus.s_tready), 64'd0);
        @(negedge clk);
        en = 1'b0;
        chk("t6_en_fill", 64'(fill_beats), 64'd0);
        chk("t6_en_count", 64'(pkt_count), 64'd0);
        chk("t6_en_valid", 64'(bus.data_valid), 64'd0);
        send(64'd400, 64, 1'b0, stalls);
        chk("t6_valid", 64'(bus.data_valid), 64'd1);
        chk("t6_word0", bus.data[63:0], w0(64'd400, 0));
        chk_pkt("t6_pkt", model(64, 0));
        pulse_next();
        chk("t6_only_one", 64'(bus.data_valid), 64'd0);
        chk("t6_pkt_count", 64'(pkt_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
